lcd_frame_ctrl: RTL and testbench

- Sequences one LCD frame transfer from the frame-buffer memory to the LCD bus writer.
- Drives the enable of the external frame address counter (range ADDR_FIRST..ADDR_LAST, wraps to ADDR_FIRST) and issues memory read strobes.
- Sends the RAM-write command word, then streams pixels with a valid/ready handshake.
- Sits between the AHB LCD control register block (start/abort/continuous) and the LCD bus writer.

---
 rtl/lcd_pkg.sv | 24 ++
 rtl/lcd_frame_ctrl_if.sv | 26 ++
 rtl/lcd_frame_ctrl.sv | 148 ++++++++++++++
 tb/tb_lcd_frame_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and FSM encoding for the LCD frame transfer path.
// The address window is shared with the external address counter and the bench model.
package lcd_pkg;

  localparam logic [15:0] CMD_RAMWR      = 16'h002C;
  localparam int unsigned LCD_ADDR_FIRST = 108;
  localparam int unsigned LCD_ADDR_LAST  = 6518;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCmd   = 3'd1,
    StFetch = 3'd2,
    StWait  = 3'd3,
    StSend  = 3'd4,
    StDrain = 3'd5,
    StDone  = 3'd6
  } lcd_state_e;

  // Number of pixels in one frame, inclusive of both window ends.
  function automatic int unsigned frame_pixels();
    return LCD_ADDR_LAST - LCD_ADDR_FIRST + 1;
  endfunction

endpackage

// File: rtl/lcd_frame_ctrl_if.sv
// Word stream from the frame controller to the LCD bus writer: valid/ready with a
// data/command flag travelling alongside each word.
interface lcd_frame_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16
);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_dc;

  modport master (
    output wr_valid,
    output wr_data,
    output wr_dc,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_dc,
    output wr_ready
  );

endinterface

// File: rtl/lcd_frame_ctrl.sv
// Sequences one LCD frame: RAM-write command, then one fetch/send round per pixel,
// driving the external address counter so it always rests at the first address in idle.
module lcd_frame_ctrl #(
  parameter int unsigned           ADDR_WIDTH  = 17,
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] CMD_RAMWR   = lcd_pkg::CMD_RAMWR,
  parameter int unsigned           FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   cont_i,
  output logic                   cnt_en_o,
  input  logic                   trans_stop_i,
  output logic                   mem_rd_o,
  input  logic [DATA_WIDTH-1:0]  mem_rdata_i,
  lcd_frame_ctrl_if.master       wr,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

  import lcd_pkg::*;

  if (ADDR_WIDTH < $clog2(LCD_ADDR_LAST + 1)) begin : g_addr_width_check
    $error("ADDR_WIDTH cannot reach the last frame-buffer address");
  end

  lcd_state_e             state_q;
  logic                   valid_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   dc_q;
  logic                   rd_q;
  logic                   busy_q;
  logic                   done_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      valid_q     <= 1'b0;
      data_q      <= '0;
      dc_q        <= 1'b0;
      rd_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // start wins over a simultaneous abort; abort alone is ignored here
          if (start_i) begin
            state_q <= StCmd;
            valid_q <= 1'b1;
            dc_q    <= 1'b0;
            data_q  <= CMD_RAMWR;
            busy_q  <= 1'b1;
          end
        end
        StCmd: begin
          // Counter has not moved yet, so an abort here needs no drain
          if (abort_i) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (wr.wr_ready) begin
            state_q <= StFetch;
            valid_q <= 1'b0;
            rd_q    <= 1'b1;
          end
        end
        StFetch: begin
          state_q <= abort_i ? StDrain : StWait;
        end
        StWait: begin
          if (abort_i) begin
            state_q <= StDrain;
          end else begin
            state_q <= StSend;
            valid_q <= 1'b1;
            dc_q    <= 1'b1;
            data_q  <= mem_rdata_i;
          end
        end
        StSend: begin
          if (abort_i) begin
            // An accepted-and-aborted pixel is dropped but still advanced the counter
            valid_q <= 1'b0;
            if (wr.wr_ready && trans_stop_i) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StDrain;
            end
          end else if (wr.wr_ready) begin
            valid_q <= 1'b0;
            if (trans_stop_i) begin
              state_q     <= StDone;
              done_q      <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end else begin
              state_q <= StFetch;
              rd_q    <= 1'b1;
            end
          end
        end
        StDrain: begin
          if (trans_stop_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StDone: begin
          if (cont_i) begin
            state_q <= StCmd;
            valid_q <= 1'b1;
            dc_q    <= 1'b0;
            data_q  <= CMD_RAMWR;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // The counter must step in the same cycle the writer takes the pixel, so this
  // enable is decoded from the state register rather than registered itself.
  assign cnt_en_o = ((state_q == StSend) && wr.wr_ready) || (state_q == StDrain);

  assign mem_rd_o    = rd_q;
  assign wr.wr_valid = valid_q;
  assign wr.wr_data  = data_q;
  assign wr.wr_dc    = dc_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_lcd_frame_ctrl.sv
// Directed bench for lcd_frame_ctrl with a behavioural address counter and frame-buffer
// model; a negedge monitor scores every accepted word and handshake hold.
module tb_lcd_frame_ctrl;

  import lcd_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned FW = 8;
  localparam logic [16:0] A_FIRST = 17'd108;
  localparam logic [16:0] A_LAST  = 17'd6518;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cont = 1'b0;
  logic          cnt_en;
  logic          trans_stop;
  logic          mem_rd;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;
  logic          done;
  logic [FW-1:0] frame_cnt;

  logic          rand_mode = 1'b0;
  logic          ready_level = 1'b1;
  logic          rnd_bit = 1'b1;
  logic          preset_en = 1'b0;
  logic [16:0]   preset_val = A_FIRST;
  logic [16:0]   exp_base = A_FIRST;
  logic [16:0]   cnt_addr;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int pix_cnt = 0;
  int cmd_cnt = 0;
  int done_cnt = 0;
  int en_cnt = 0;
  int valid_cnt = 0;

  lcd_frame_ctrl_if #(.DATA_WIDTH(DW)) wr_bus ();

  lcd_frame_ctrl #(
    .ADDR_WIDTH  (17),
    .DATA_WIDTH  (DW),
    .CMD_RAMWR   (16'h002C),
    .FRAME_CNT_W (FW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_i      (start),
    .abort_i      (abort),
    .cont_i       (cont),
    .cnt_en_o     (cnt_en),
    .trans_stop_i (trans_stop),
    .mem_rd_o     (mem_rd),
    .mem_rdata_i  (mem_rdata),
    .wr           (wr_bus),
    .busy_o       (busy),
    .done_o       (done),
    .frame_cnt_o  (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_bit <= ($urandom_range(0, 9) >= 3);
  end

  assign wr_bus.wr_ready = rand_mode ? rnd_bit : ready_level;

  function automatic logic [15:0] pix(input logic [16:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [16:0] next_addr(input logic [16:0] a);
    return (a == A_LAST) ? A_FIRST : a + 17'd1;
  endfunction

  // External address counter and synchronous-read frame buffer
  always @(posedge clk or negedge rstn) begin
    if (!rstn)          cnt_addr <= A_FIRST;
    else if (preset_en) cnt_addr <= preset_val;
    else if (cnt_en)    cnt_addr <= next_addr(cnt_addr);
  end

  assign trans_stop = (cnt_addr == A_LAST);

  always @(posedge clk) if (mem_rd) mem_rdata <= pix(cnt_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {2'b00, cnt_en, mem_rd, wr_bus.wr_valid, wr_bus.wr_dc, busy, done, frame_cnt,
            wr_bus.wr_data};
  endfunction

  // Monitor: accepted words, hold-while-stalled, event counters
  logic          stall_q = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic          hold_dc = 1'b0;
  logic [16:0]   exp_addr = A_FIRST;

  always @(negedge clk) begin
    if (!rstn) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q)
        check("hold_stable", {15'd0, wr_bus.wr_valid, wr_bus.wr_dc, wr_bus.wr_data},
              {15'd0, 1'b1, hold_dc, hold_data});
      if (wr_bus.wr_valid && wr_bus.wr_ready && !abort) begin
        if (!wr_bus.wr_dc) begin
          check("cmd_word", {16'd0, wr_bus.wr_data}, 32'h0000_002C);
          cmd_cnt  <= cmd_cnt + 1;
          exp_addr <= exp_base;
        end else begin
          check("pix_data", {16'd0, wr_bus.wr_data}, {16'd0, pix(exp_addr)});
          check("pix_addr", {15'd0, cnt_addr}, {15'd0, exp_addr});
          pix_cnt  <= pix_cnt + 1;
          exp_addr <= next_addr(exp_addr);
        end
      end
      stall_q   <= wr_bus.wr_valid && !wr_bus.wr_ready && !abort;
      hold_data <= wr_bus.wr_data;
      hold_dc   <= wr_bus.wr_dc;
      if (done)            done_cnt  <= done_cnt + 1;
      if (cnt_en)          en_cnt    <= en_cnt + 1;
      if (wr_bus.wr_valid) valid_cnt <= valid_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_pix, b_cmd, b_done, b_en, b_valid, n, d, last_c;

    // Reset state
    tick();
    tick();
    check("reset_outputs", outs(), 32'd0);
    rstn = 1'b1;
    tick();

    // Single frame under random backpressure (about 30% stall)
    rand_mode = 1'b1;
    b_pix = pix_cnt; b_cmd = cmd_cnt; b_done = done_cnt; b_en = en_cnt;
    pulse_start();
    check("start_latency", {29'd0, busy, wr_bus.wr_valid, wr_bus.wr_dc}, 32'b110);
    n = 0;
    while (!done && n < 60000) begin tick(); n++; end
    if (!done) check("frame_timeout", 32'd0, 32'd1);
    else       check("frame_cnt_1", {24'd0, frame_cnt}, 32'd1);
    tick();
    rand_mode = 1'b0;
    check("busy_fall", {31'd0, busy}, 32'd0);
    check("bp_pixels", pix_cnt - b_pix, 32'd6411);
    check("bp_cmds", cmd_cnt - b_cmd, 32'd1);
    check("bp_done", done_cnt - b_done, 32'd1);
    check("bp_cnt_en", en_cnt - b_en, 32'd6411);
    check("bp_ctr_wrap", {15'd0, cnt_addr}, 32'd108);

    // Continuous mode, three frames, writer always ready
    reset_dut();
    ready_level = 1'b1;
    cont = 1'b1;
    b_pix = pix_cnt; b_cmd = cmd_cnt; b_done = done_cnt;
    pulse_start();
    check("cmd_valid", {30'd0, wr_bus.wr_valid, wr_bus.wr_dc}, 32'b10);
    tick();
    check("fetch_after_cmd", {30'd0, wr_bus.wr_valid, mem_rd}, 32'b01);
    tick();
    check("wait_state", {30'd0, wr_bus.wr_valid, mem_rd}, 32'b00);
    tick();
    check("first_pix_valid", {30'd0, wr_bus.wr_valid, wr_bus.wr_dc}, 32'b11);
    d = 0; n = 0; last_c = 0;
    while (d < 3 && n < 70000) begin
      if (done) begin
        d++;
        if (d > 1) check("frame_period", cyc - last_c, 32'd19235);
        last_c = cyc;
        if (d < 3) begin
          tick(); n++;
          check("no_idle_gap", {29'd0, busy, wr_bus.wr_valid, wr_bus.wr_dc}, 32'b110);
          if (d == 2) cont = 1'b0;
        end
      end
      if (d < 3) begin tick(); n++; end
    end
    if (d < 3) check("cont_timeout", d, 32'd3);
    check("frame_cnt_3", {24'd0, frame_cnt}, 32'd3);
    tick();
    check("cont_idle", {31'd0, busy}, 32'd0);
    check("cont_pixels", pix_cnt - b_pix, 32'd19233);
    check("cont_cmds", cmd_cnt - b_cmd, 32'd3);
    check("cont_done", done_cnt - b_done, 32'd3);

    // Abort while the 500th pixel is pending
    b_pix = pix_cnt; b_done = done_cnt;
    pulse_start();
    n = 0;
    while (!(wr_bus.wr_valid && wr_bus.wr_dc && (pix_cnt - b_pix == 499)) && n < 5000) begin
      tick(); n++;
    end
    if (n >= 5000) check("abort500_timeout", 32'd0, 32'd1);
    b_en = en_cnt;
    ready_level = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ready_level = 1'b1;
    check("abort_valid_drop", {31'd0, wr_bus.wr_valid}, 32'd0);
    check("drain_cnt_en", {31'd0, cnt_en}, 32'd1);
    b_valid = valid_cnt;
    n = 0;
    while (busy && n < 8000) begin tick(); n++; end
    check("drain_ends", {31'd0, busy}, 32'd0);
    check("drain_pulses", en_cnt - b_en, 32'd5912);
    check("drain_no_valid", valid_cnt - b_valid, 32'd0);
    check("abort_no_done", done_cnt - b_done, 32'd0);
    check("abort_frame_cnt", {24'd0, frame_cnt}, 32'd3);
    check("abort_ctr_wrap", {15'd0, cnt_addr}, 32'd108);
    check("abort_pixels", pix_cnt - b_pix, 32'd499);

    // Restart streams from the first address; then async reset in SEND
    b_pix = pix_cnt;
    pulse_start();
    n = 0;
    while (!(wr_bus.wr_valid && wr_bus.wr_dc && (pix_cnt - b_pix == 3)) && n < 100) begin
      tick(); n++;
    end
    check("restart_addr", {15'd0, cnt_addr}, 32'd111);
    rstn = 1'b0;
    #1;
    check("async_reset", outs(), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    b_pix = pix_cnt;
    pulse_start();
    check("post_reset_cmd", {29'd0, busy, wr_bus.wr_valid, wr_bus.wr_dc}, 32'b110);
    n = 0;
    while (pix_cnt - b_pix < 2 && n < 100) begin tick(); n++; end
    check("post_reset_pixels", pix_cnt - b_pix, 32'd2);
    reset_dut();

    // start+abort in IDLE: start wins; then abort in CMD goes straight to IDLE
    ready_level = 1'b0;
    b_en = en_cnt; b_cmd = cmd_cnt;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    check("start_wins", {29'd0, busy, wr_bus.wr_valid, wr_bus.wr_dc}, 32'b110);
    tick();
    abort = 1'b0;
    check("cmd_abort_idle", {30'd0, busy, wr_bus.wr_valid}, 32'd0);
    tick();
    ready_level = 1'b1;
    check("cmd_abort_no_en", en_cnt - b_en, 32'd0);
    check("cmd_abort_no_cmd", cmd_cnt - b_cmd, 32'd0);
    check("cmd_abort_ctr", {15'd0, cnt_addr}, 32'd108);

    // Abort coinciding with acceptance of the last pixel (short frame via preset)
    exp_base   = A_LAST - 17'd3;
    preset_val = A_LAST - 17'd3;
    preset_en  = 1'b1;
    tick();
    preset_en  = 1'b0;
    b_pix = pix_cnt; b_en = en_cnt; b_done = done_cnt;
    pulse_start();
    n = 0;
    while (!(wr_bus.wr_valid && wr_bus.wr_dc && trans_stop) && n < 100) begin
      tick(); n++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("last_abort_idle", {31'd0, busy}, 32'd0);
    check("last_abort_wrap", {15'd0, cnt_addr}, 32'd108);
    tick();
    check("last_abort_en", en_cnt - b_en, 32'd4);
    check("last_abort_pixels", pix_cnt - b_pix, 32'd3);
    check("last_abort_no_done", done_cnt - b_done, 32'd0);
    check("last_abort_fcnt", {24'd0, frame_cnt}, 32'd0);
    exp_base = A_FIRST;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
